// File: rtl/opl3_pkg.sv
// Register map, state encoding and host-write record shared by the timer poll detector.
package opl3_pkg;

  localparam int REG_TIMER_WIDTH     = 8;
  localparam int REG_FILE_DATA_WIDTH = 8;

  localparam logic [REG_FILE_DATA_WIDTH-1:0] REG_TIMER1     = 8'h02;
  localparam logic [REG_FILE_DATA_WIDTH-1:0] REG_TIMER2     = 8'h03;
  localparam logic [REG_FILE_DATA_WIDTH-1:0] REG_TIMER_CTRL = 8'h04;

  typedef enum logic [1:0] {
    TP_IDLE,
    TP_ARMED,
    TP_FIRED
  } tp_state_e;

  // One decoded register write: latched bank/register plus the data byte.
  typedef struct packed {
    logic                           vld;
    logic                           bank;
    logic [REG_FILE_DATA_WIDTH-1:0] addr;
    logic [REG_FILE_DATA_WIDTH-1:0] data;
  } reg_wr_t;

  // Reload register that feeds timer idx (0 = timer 1).
  function automatic logic [REG_FILE_DATA_WIDTH-1:0] timer_reg(input int idx);
    return (idx == 0) ? REG_TIMER1 : REG_TIMER2;
  endfunction

endpackage

// File: rtl/timer_poll_channel.sv
// One timer's poll counter and IDLE/ARMED/FIRED FSM.
// FORCE_OVERFLOW_AUTOCLEAR_EN: FIRED lasts one cycle and re-arms with a cleared count.
module timer_poll_channel
  import opl3_pkg::*;
#(
  parameter int NUM_READS_TO_TRIGGER = 50
) (
  input  logic clk,
  input  logic reset,
  input  logic arm_i,
  input  logic cancel_i,
  input  logic rd_edge_i,
  output logic force_o
);

  localparam int               CNT_W    = $clog2(NUM_READS_TO_TRIGGER + 1);
  localparam logic [CNT_W-1:0] CNT_TRIG = CNT_W'(NUM_READS_TO_TRIGGER);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  tp_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             force_q;

  always_comb begin
    cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    state_d = state_q;
    cnt_d   = cnt_q;
    // Any register write outranks a read landing in the same cycle.
    if (arm_i) begin
      state_d = TP_ARMED;
      cnt_d   = '0;
    end else if (cancel_i) begin
      state_d = TP_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        TP_ARMED: begin
          if (rd_edge_i) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_TRIG) state_d = TP_FIRED;
          end
        end
        TP_FIRED: begin
`ifdef FORCE_OVERFLOW_AUTOCLEAR_EN
          state_d = TP_ARMED;
          cnt_d   = '0;
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= TP_IDLE;
      cnt_q   <= '0;
      force_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      force_q <= (state_d == TP_FIRED);
    end
  end

  assign force_o = force_q;

endmodule

// File: rtl/timer_poll_detector.sv
// Watches host register traffic and forces a timer overflow after repeated status polls.
// FORCE_OVERFLOW_AUTOCLEAR_EN turns the force level into a periodic one-cycle pulse.
module timer_poll_detector
  import opl3_pkg::*;
#(
  parameter int                         NUM_TIMERS           = 2,
  parameter int                         NUM_READS_TO_TRIGGER = 50,
  parameter logic [REG_TIMER_WIDTH-1:0] TRIGGER_TIMER_VALUE  = 'hFF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cs_n,
  input  logic                           rd_n,
  input  logic                           wr_n,
  input  logic [1:0]                     address,
  input  logic [REG_FILE_DATA_WIDTH-1:0] din,
  output logic [NUM_TIMERS-1:0]          force_timer_overflow
);

  logic                           cs_n_q, rd_n_q, wr_n_q;
  logic [1:0]                     address_q;
  logic [REG_FILE_DATA_WIDTH-1:0] din_q;
  logic                           wr_act, rd_act, wr_act_q, rd_act_q;
  logic                           wr_edge, rd_edge;
  logic                           bank_q;
  logic [REG_FILE_DATA_WIDTH-1:0] reg_q;
  reg_wr_t                        wr_q;
  logic [NUM_TIMERS-1:0][REG_TIMER_WIDTH-1:0] shadow_q;
  logic [NUM_TIMERS-1:0]          arm, cancel;

  always_comb begin
    wr_act  = !cs_n_q && !wr_n_q;
    rd_act  = !cs_n_q && !rd_n_q;
    wr_edge = wr_act && !wr_act_q;
    rd_edge = rd_act && !rd_act_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cs_n_q    <= 1'b1;
      rd_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      address_q <= '0;
      din_q     <= '0;
      wr_act_q  <= 1'b0;
      rd_act_q  <= 1'b0;
      bank_q    <= 1'b0;
      reg_q     <= '0;
      wr_q      <= '0;
    end else begin
      cs_n_q    <= cs_n;
      rd_n_q    <= rd_n;
      wr_n_q    <= wr_n;
      address_q <= address;
      din_q     <= din;
      wr_act_q  <= wr_act;
      rd_act_q  <= rd_act;
      wr_q      <= '0;
      if (wr_edge) begin
        if (!address_q[0]) begin
          bank_q <= address_q[1];
          reg_q  <= din_q;
        end else begin
          wr_q <= '{vld: 1'b1, bank: bank_q, addr: reg_q, data: din_q};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q <= '0;
    end else begin
      for (int i = 0; i < NUM_TIMERS; i++) begin
        if (wr_q.vld && !wr_q.bank && wr_q.addr == timer_reg(i))
          shadow_q[i] <= wr_q.data[REG_TIMER_WIDTH-1:0];
      end
    end
  end

  // Every data write either arms a timer or cancels it; nothing is left untouched.
  always_comb begin
    arm    = '0;
    cancel = '0;
    for (int i = 0; i < NUM_TIMERS; i++) begin
      arm[i]    = wr_q.vld && !wr_q.bank && (wr_q.addr == REG_TIMER_CTRL) &&
                  wr_q.data[i] && (shadow_q[i] == TRIGGER_TIMER_VALUE);
      cancel[i] = wr_q.vld && !arm[i];
    end
  end

  timer_poll_channel #(
    .NUM_READS_TO_TRIGGER(NUM_READS_TO_TRIGGER)
  ) u_ch [NUM_TIMERS-1:0] (
    .clk      (clk),
    .reset    (reset),
    .arm_i    (arm),
    .cancel_i (cancel),
    .rd_edge_i({NUM_TIMERS{rd_edge}}),
    .force_o  (force_timer_overflow)
  );

endmodule

// File: tb/tb_timer_poll_detector.sv
// Randomized bench for timer_poll_detector against a transaction-level poll model.
module tb_timer_poll_detector;
  import opl3_pkg::*;

  localparam int         NT   = 2;
  localparam int         NR   = 50;
  localparam logic [7:0] TRIG = 8'hFF;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cs_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
  logic [1:0]    address = '0;
  logic [7:0]    din = '0;
  logic [NT-1:0] force_ov;

  timer_poll_detector #(
    .NUM_TIMERS(NT), .NUM_READS_TO_TRIGGER(NR), .TRIGGER_TIMER_VALUE(TRIG)
  ) dut (
    .clk(clk), .reset(reset), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n),
    .address(address), .din(din), .force_timer_overflow(force_ov)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Edge/level monitor on the force outputs.
  logic [NT-1:0] prev_f = '0;
  int            rises[NT];
  int            hi_cyc[NT];
  initial for (int i = 0; i < NT; i++) begin rises[i] = 0; hi_cyc[i] = 0; end
  always @(posedge clk) begin
    prev_f <= force_ov;
    for (int i = 0; i < NT; i++) begin
      if (force_ov[i] === 1'b1 && prev_f[i] === 1'b0) rises[i] <= rises[i] + 1;
      if (force_ov[i] === 1'b1) hi_cyc[i] <= hi_cyc[i] + 1;
    end
  end

  // Reference model: one step per completed host transaction.
  bit         m_bank;
  logic [7:0] m_reg;
  logic [7:0] m_shadow[NT];
  bit         m_armed[NT];
  bit         m_fired[NT];
  int         m_cnt[NT];
  int         m_fires[NT];

  task automatic m_reset();
    m_bank = 0;
    m_reg  = '0;
    for (int i = 0; i < NT; i++) begin
      m_shadow[i] = '0; m_armed[i] = 0; m_fired[i] = 0; m_cnt[i] = 0;
    end
  endtask

  task automatic m_data(input logic [7:0] d);
    for (int i = 0; i < NT; i++) begin
      m_armed[i] = (!m_bank && m_reg == 8'h04 && d[i] && m_shadow[i] == TRIG);
      m_fired[i] = 0;
      m_cnt[i]   = 0;
    end
    for (int i = 0; i < NT; i++)
      if (!m_bank && m_reg == 8'(8'h02 + i)) m_shadow[i] = d;
  endtask

  task automatic m_read();
    for (int i = 0; i < NT; i++) begin
      if (m_armed[i] && !m_fired[i]) begin
        m_cnt[i]++;
        if (m_cnt[i] == NR) begin
          m_fires[i]++;
`ifdef FORCE_OVERFLOW_AUTOCLEAR_EN
          m_cnt[i] = 0;
`else
          m_fired[i] = 1;
`endif
        end
      end
    end
  endtask

  function automatic logic [NT-1:0] exp_force();
    logic [NT-1:0] f;
    f = '0;
`ifndef FORCE_OVERFLOW_AUTOCLEAR_EN
    for (int i = 0; i < NT; i++) f[i] = m_fired[i];
`endif
    return f;
  endfunction

  // Host bus cycle: strobe low for two clocks, then idle long enough to settle.
  task automatic bus(input bit is_wr, input bit sel, input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    cs_n = !sel; address = a; din = d;
    if (is_wr) wr_n = 1'b0; else rd_n = 1'b0;
    repeat (2) @(negedge clk);
    cs_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic latch(input bit bank, input logic [7:0] r);
    bus(1, 1, {bank, 1'b0}, r);
    m_bank = bank; m_reg = r;
    chk("latch", 32'(force_ov), 32'(exp_force()));
  endtask

  task automatic wdata(input logic [7:0] d);
    bus(1, 1, {1'($urandom), 1'b1}, d);
    m_data(d);
    chk("data_wr", 32'(force_ov), 32'(exp_force()));
  endtask

  task automatic wr_reg(input bit bank, input logic [7:0] r, input logic [7:0] d);
    latch(bank, r);
    wdata(d);
  endtask

  task automatic rd(input string tag);
    bus(0, 1, 2'($urandom), 8'($urandom));
    m_read();
    chk(tag, 32'(force_ov), 32'(exp_force()));
  endtask

  // Data write whose pulse lands in the same cycle as a read edge.
  task automatic wr_rd(input logic [7:0] d);
    @(negedge clk);
    cs_n = 1'b0; address = 2'b01; din = d; wr_n = 1'b0;
    @(negedge clk);
    wr_n = 1'b1; rd_n = 1'b0;
    @(negedge clk);
    rd_n = 1'b1; cs_n = 1'b1;
    repeat (3) @(negedge clk);
    m_data(d);
    chk("wr_rd", 32'(force_ov), 32'(exp_force()));
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("in_reset", 32'(force_ov), 32'(0));
    reset = 1'b0;
    m_reset();
  endtask

  task automatic rand_wr();
    logic [7:0] regs[8];
    logic [7:0] r, d;
    regs = '{8'h02, 8'h03, 8'h04, 8'h04, 8'h04, 8'h05, 8'h02, 8'h03};
    r = regs[$urandom % 8];
    if (r == 8'h04)      d = 8'($urandom % 4);
    else if ($urandom % 4 != 0) d = 8'hFF;
    else                 d = 8'($urandom);
    wr_reg(($urandom % 8) == 0, r, d);
  endtask

  int r0, r1, h0, nops, sel;
  logic [NT-1:0] f1, f2, f3;

  initial begin
    m_reset();
    for (int i = 0; i < NT; i++) m_fires[i] = 0;
    repeat (3) @(negedge clk);
    chk("reset_state", 32'(force_ov), 32'(0));
    reset = 1'b0;

    // 50 polls with timer 1 reload at FF; last read checked cycle by cycle.
    wr_reg(0, 8'h02, 8'hFF);
    wr_reg(0, 8'h04, 8'h01);
    for (int k = 0; k < NR - 1; k++) rd("arm_50");
    @(negedge clk);
    cs_n = 1'b0; rd_n = 1'b0;
    @(negedge clk); f1 = force_ov;
    @(negedge clk); f2 = force_ov;
    cs_n = 1'b1; rd_n = 1'b1;
    @(negedge clk); f3 = force_ov;
    repeat (2) @(negedge clk);
    m_read();
    chk("nth_before_edge", 32'(f1), 32'(0));
    chk("nth_after_edge", 32'(f2), 32'(2'b01));
`ifdef FORCE_OVERFLOW_AUTOCLEAR_EN
    chk("nth_autoclear", 32'(f3), 32'(0));
`else
    chk("nth_held", 32'(f3), 32'(2'b01));
`endif

    // 49 polls then an unrelated write: never fires.
    wr_reg(0, 8'h04, 8'h01);
    for (int k = 0; k < NR - 1; k++) rd("arm_49");
    wr_reg(0, 8'h05, 8'h00);
    for (int k = 0; k < 60; k++) rd("cancel_05");

    // Reload mismatch: arming is refused.
    wr_reg(0, 8'h02, 8'hFE);
    wr_reg(0, 8'h04, 8'h01);
    for (int k = 0; k < 60; k++) rd("mismatch");

    // Timer 2, then clear via control write.
    wr_reg(0, 8'h03, 8'hFF);
    wr_reg(0, 8'h04, 8'h02);
    for (int k = 0; k < NR; k++) rd("timer2");
    wr_reg(0, 8'h04, 8'h00);

    // Arm coinciding with a read: that read must not count.
    wr_reg(0, 8'h02, 8'hFF);
    latch(0, 8'h04);
    wr_rd(8'h01);
    for (int k = 0; k < NR; k++) rd("prio");

    // Reset mid-count aborts the sequence.
    wr_reg(0, 8'h04, 8'h01);
    for (int k = 0; k < 30; k++) rd("pre_reset");
    do_reset();
    for (int k = 0; k < 20; k++) rd("post_reset");

    // 100 polls after a single arm.
    wr_reg(0, 8'h02, 8'hFF);
    wr_reg(0, 8'h04, 8'h01);
    r0 = rises[0]; h0 = hi_cyc[0];
    for (int k = 0; k < 2 * NR; k++) rd("poll_100");
`ifdef FORCE_OVERFLOW_AUTOCLEAR_EN
    chk("two_pulses", 32'(rises[0] - r0), 32'(2));
    chk("pulse_width", 32'(hi_cyc[0] - h0), 32'(2));
`else
    chk("one_rise", 32'(rises[0] - r0), 32'(1));
`endif

    // Random segments: a few writes then a burst of mostly reads.
    for (int s = 0; s < 24; s++) begin
      repeat (1 + $urandom % 3) rand_wr();
      nops = $urandom_range(20, 80);
      for (int k = 0; k < nops; k++) begin
        sel = $urandom % 100;
        if (sel < 92) rd("rnd_rd");
        else if (sel < 95) latch(1'($urandom), 8'($urandom % 8));
        else if (sel < 98) begin
          bus(1'($urandom), 0, 2'($urandom), 8'($urandom));
          chk("deselect", 32'(force_ov), 32'(exp_force()));
        end else if (sel < 99) wr_rd(8'($urandom % 4));
        else do_reset();
      end
    end

    repeat (3) @(negedge clk);
    for (int i = 0; i < NT; i++) begin
`ifdef FORCE_OVERFLOW_AUTOCLEAR_EN
      chk("fire_cycles", 32'(hi_cyc[i]), 32'(m_fires[i]));
`endif
      chk("fire_count", 32'(rises[i]), 32'(m_fires[i]));
    end
    r1 = m_fires[0];
    chk("fired_once_min", 32'(r1 > 0), 32'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
